// File: rtl/led_pattern_gen_if.sv
// rtl/led_pattern_gen_if.sv - control/status bundle for the LED pattern sequencer
//
// Purpose: groups the run/mode controls and the LED/step outputs of
//          led_pattern_gen so they travel as one port.
// Optional feature macro: LED_PWM_EN (adds the duty input).
// Signals:
//   en    run enable (master -> slave)
//   mode  pattern mode 0 ROTL, 1 ROTR, 2 BOUNCE, 3 BLINK (master -> slave)
//   duty  PWM duty 0..255, LED_PWM_EN builds only (master -> slave)
//   step  one-cycle pulse when the pattern advances (slave -> master)
//   ledr  LED drive, 1 = lit (slave -> master)
interface led_pattern_gen_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [1:0]       mode;
  logic             step;
  logic [WIDTH-1:0] ledr;
`ifdef LED_PWM_EN
  logic [7:0]       duty;

  modport master (output en, output mode, output duty, input step, input ledr);
  modport slave  (input en, input mode, input duty, output step, output ledr);
`else
  modport master (output en, output mode, input step, input ledr);
  modport slave  (input en, input mode, output step, output ledr);
`endif
endinterface

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - parametrised LED pattern sequencer
//
// Purpose: steps a WIDTH-bit LED pattern once every PERIOD enabled cycles in
//          one of four modes (rotate left, rotate right, bounce, blink).
// Optional feature macro: LED_PWM_EN (8-bit PWM dimming of the LED outputs).
// Parameters:
//   WIDTH   number of LEDs, 2..64
//   PERIOD  clk cycles per pattern step, >= 1
//   CNT_W   prescaler width, 2**CNT_W > PERIOD
// Ports:
//   clk    clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    led_pattern_gen_if slave: en, mode, [duty] in; step, ledr out
module led_pattern_gen #(
  parameter int WIDTH  = 16,
  parameter int PERIOD = 5000000,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  led_pattern_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    ROTL   = 2'd0,
    ROTR   = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [WIDTH-1:0] PAT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] PAT_ALL  = {WIDTH{1'b1}};

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pat;
  logic [WIDTH-1:0] pat_nx;
  dir_e             dir;
  dir_e             dir_nx;
  mode_e            mode_q;
  mode_e            mode_in;
  logic             step_q;
  logic             mode_chg;

  assign mode_in  = mode_e'(bus.mode);
  assign mode_chg = (mode_in != mode_q);

  // Pattern value for the next step, computed from the mode that is
  // currently in force (mode_q); a differing live mode reloads instead.
  always_comb begin
    pat_nx = pat;
    dir_nx = dir;
    unique case (mode_q)
      ROTL:   pat_nx = {pat[WIDTH-2:0], pat[WIDTH-1]};
      ROTR:   pat_nx = {pat[0], pat[WIDTH-1:1]};
      BOUNCE: begin
        // Reverse on the step that leaves an end bit, so the end bit is
        // shown for exactly one step.
        if (dir == LEFT && pat[WIDTH-1]) begin
          dir_nx = RIGHT;
          pat_nx = pat >> 1;
        end else if (dir == RIGHT && pat[0]) begin
          dir_nx = LEFT;
          pat_nx = pat << 1;
        end else if (dir == LEFT) begin
          pat_nx = pat << 1;
        end else begin
          pat_nx = pat >> 1;
        end
      end
      BLINK:  pat_nx = ~pat;
      default: pat_nx = pat;
    endcase
  end

  // Prescaler, pattern, direction and step strobe. A mode change wins over
  // a coincident tick and is applied regardless of en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat    <= PAT_ONE;
      cnt    <= '0;
      dir    <= LEFT;
      step_q <= 1'b0;
      mode_q <= mode_in;
    end else begin
      mode_q <= mode_in;
      if (mode_chg) begin
        cnt    <= '0;
        dir    <= LEFT;
        step_q <= 1'b0;
        pat    <= (mode_in == BLINK) ? PAT_ALL : PAT_ONE;
      end else if (bus.en) begin
        if (cnt == CNT_LAST) begin
          cnt    <= '0;
          pat    <= pat_nx;
          dir    <= dir_nx;
          step_q <= 1'b1;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          step_q <= 1'b0;
        end
      end else begin
        step_q <= 1'b0;
      end
    end
  end

  assign bus.step = step_q;

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running so brightness does not depend on en or mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  assign bus.ledr = pat & {WIDTH{pwm_cnt < bus.duty}};
`else
  assign bus.ledr = pat;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - self-checking bench for led_pattern_gen
module tb_led_pattern_gen;

  localparam int W = 4;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tb_pwm = 0;

  always #5 clk = ~clk;

  led_pattern_gen_if #(.WIDTH(W)) bus ();

  led_pattern_gen #(.WIDTH(W), .PERIOD(P), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic         step;
    logic [W-1:0] ledr;
    string        name;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] bseq[8];

  task automatic add(input logic r, input logic e, input logic [1:0] m,
                     input logic s, input logic [W-1:0] l, input string nm);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.step = s; v.ledr = l; v.name = nm;
    tbl.push_back(v);
  endtask

  // Drive one cycle, then compare step and ledr 1 time unit after the edge.
  task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                     input logic s_e, input logic [W-1:0] l_e, input string nm);
    logic [W-1:0] l_x;
    rst_n   = r;
    bus.en  = e;
    bus.mode = m;
    @(posedge clk);
    #1;
    tb_pwm = r ? ((tb_pwm + 1) % 256) : 0;
    l_x = l_e;
`ifdef LED_PWM_EN
    if (!(tb_pwm < int'(bus.duty))) l_x = '0;
`endif
    n_cmp++;
    if (bus.step !== s_e) begin
      n_bad++;
      $display("FAIL %s step: got %0b want %0b (t=%0t)", nm, bus.step, s_e, $time);
    end
    n_cmp++;
    if (bus.ledr !== l_x) begin
      n_bad++;
      $display("FAIL %s ledr: got %b want %b (t=%0t)", nm, bus.ledr, l_x, $time);
    end
  endtask

  // Run BOUNCE for nsteps steps from reset, checking every cycle.
  task automatic run_bounce(input int nsteps, input string nm);
    logic [W-1:0] cur;
    cur = 4'b0001;
    for (int s = 0; s < nsteps; s++) begin
      for (int c = 0; c < P; c++) begin
        if (c == P - 1) cur = bseq[s];
        cyc(1'b1, 1'b1, 2'd2, (c == P - 1), cur, nm);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.mode = 2'd0;
`ifdef LED_PWM_EN
    bus.duty = 8'd255;
`endif
    bseq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
             4'b0010, 4'b0001, 4'b0010, 4'b0100};

    // Reset then ROTL at PERIOD=4.
    add(0, 1, 0, 0, 4'b0001, "rst0");
    add(0, 1, 0, 0, 4'b0001, "rst1");
    add(1, 1, 0, 0, 4'b0001, "rotl_c1");
    add(1, 1, 0, 0, 4'b0001, "rotl_c2");
    add(1, 1, 0, 0, 4'b0001, "rotl_c3");
    add(1, 1, 0, 1, 4'b0010, "rotl_s1");
    add(1, 1, 0, 0, 4'b0010, "rotl_c5");
    add(1, 1, 0, 0, 4'b0010, "rotl_c6");
    add(1, 1, 0, 0, 4'b0010, "rotl_c7");
    add(1, 1, 0, 1, 4'b0100, "rotl_s2");
    add(1, 1, 0, 0, 4'b0100, "rotl_c9");
    add(1, 1, 0, 0, 4'b0100, "rotl_c10");
    add(1, 1, 0, 0, 4'b0100, "rotl_c11");
    add(1, 1, 0, 1, 4'b1000, "rotl_s3");
    add(1, 1, 0, 0, 4'b1000, "rotl_c13");
    add(1, 1, 0, 0, 4'b1000, "rotl_c14");
    add(1, 1, 0, 0, 4'b1000, "rotl_c15");
    add(1, 1, 0, 1, 4'b0001, "rotl_s4_wrap");

    foreach (tbl[i])
      cyc(tbl[i].rst_n, tbl[i].en, tbl[i].mode, tbl[i].step, tbl[i].ledr, tbl[i].name);

    // BOUNCE from reset, 8 steps.
    cyc(0, 1, 2, 0, 4'b0001, "bounce_rst");
    run_bounce(8, "bounce");

    // Pause mid-count in ROTR.
    cyc(0, 1, 1, 0, 4'b0001, "rotr_rst");
    cyc(1, 1, 1, 0, 4'b0001, "rotr_c1");
    cyc(1, 1, 1, 0, 4'b0001, "rotr_c2");
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 0, 4'b0001, "pause");
    cyc(1, 1, 1, 0, 4'b0001, "resume_c3");
    cyc(1, 1, 1, 1, 4'b1000, "resume_step");
    cyc(1, 0, 3, 0, 4'b1111, "modechg_en0");
    cyc(1, 0, 3, 0, 4'b1111, "modechg_en0_hold");

    // Mode change coinciding with a tick: ROTL -> BLINK.
    cyc(0, 1, 0, 0, 4'b0001, "tick_rst");
    for (int i = 0; i < P - 1; i++) cyc(1, 1, 0, 0, 4'b0001, "tick_pre");
    cyc(1, 1, 3, 0, 4'b1111, "chg_on_tick");
    for (int i = 0; i < P - 1; i++) cyc(1, 1, 3, 0, 4'b1111, "blink_wait1");
    cyc(1, 1, 3, 1, 4'b0000, "blink_s1");
    for (int i = 0; i < P - 1; i++) cyc(1, 1, 3, 0, 4'b0000, "blink_wait2");
    cyc(1, 1, 3, 1, 4'b1111, "blink_s2");

    // Reset mid-BOUNCE while heading right at 0100.
    cyc(0, 1, 2, 0, 4'b0001, "mid_rst_pre");
    run_bounce(4, "bounce_pre");
    cyc(1, 1, 2, 0, 4'b0100, "bounce_mid");
    cyc(0, 1, 2, 0, 4'b0001, "mid_rst");
    for (int i = 0; i < P - 1; i++) cyc(1, 1, 2, 0, 4'b0001, "post_rst_wait");
    cyc(1, 1, 2, 1, 4'b0010, "post_rst_s1");
    for (int i = 0; i < P - 1; i++) cyc(1, 1, 2, 0, 4'b0010, "post_rst_wait2");
    cyc(1, 1, 2, 1, 4'b0100, "post_rst_s2");

`ifdef LED_PWM_EN
    begin
      int lit;
      int runs;
      logic prev;
      bus.duty = 8'd64;
      cyc(0, 0, 0, 0, 4'b0001, "pwm_rst");
      for (int i = 0; i < 255; i++) cyc(1, 0, 0, 0, 4'b0001, "pwm_align");
      lit = 0; runs = 0; prev = 1'b0;
      for (int i = 0; i < 512; i++) begin
        @(posedge clk); #1;
        if (bus.ledr[0]) lit++;
        if (bus.ledr[0] && !prev) runs++;
        prev = bus.ledr[0];
      end
      n_cmp++;
      if (lit != 128) begin
        n_bad++;
        $display("FAIL pwm64_lit: got %0d want 128", lit);
      end
      n_cmp++;
      if (runs != 2) begin
        n_bad++;
        $display("FAIL pwm64_runs: got %0d want 2", runs);
      end
      bus.duty = 8'd0;
      lit = 0;
      for (int i = 0; i < 512; i++) begin
        @(posedge clk); #1;
        if (bus.ledr != '0) lit++;
      end
      n_cmp++;
      if (lit != 0) begin
        n_bad++;
        $display("FAIL pwm0_dark: got %0d lit cycles want 0", lit);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
